// File: rtl/rev_alu_seq.sv
// rev_alu_seq: handshaked WIDTH-bit ALU with iterative multiply/divide,
// Peres/Fredkin reversible-gate modes and status flags.
// Accepts one operation at a time in IDLE, iterates in BUSY for mul/div,
// and presents the result in DONE until the consumer takes it.
module rev_alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [OPW-1:0]   sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_MUL = OPW'(2);
  localparam logic [OPW-1:0] OP_DIV = OPW'(3);
  localparam logic [OPW-1:0] OP_SHL = OPW'(4);
  localparam logic [OPW-1:0] OP_SHR = OPW'(5);
  localparam logic [OPW-1:0] OP_NAND = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR = OPW'(7);
  localparam logic [OPW-1:0] OP_PRY = OPW'(8);
  localparam logic [OPW-1:0] OP_PRZ = OPW'(9);
  localparam logic [OPW-1:0] OP_FRY = OPW'(10);
  localparam logic [OPW-1:0] OP_FRZ = OPW'(11);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  // handshake / control
  logic accept_s;
  logic finish_s;
  logic is_iter_s;

  // single-cycle datapath
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_carry_s;
  logic             sc_err_s;

  // iterative datapath state
  logic [CW-1:0]      count_r;
  logic               op_div_r;
  logic               dvz_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvsr_r;

  // iterative datapath next values
  logic [2*WIDTH-1:0] acc_nx_s;
  logic [WIDTH:0]     shifted_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   rem_nx_s;
  logic [WIDTH-1:0]   quo_nx_s;
  logic [WIDTH-1:0]   fin_res_s;
  logic               fin_ovf_s;
  logic               fin_err_s;

  // registered outputs
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic             carry_r;
  logic             ovf_r;
  logic             err_r;
  logic             in_ready_r;
  logic             out_valid_r;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out        = out_r;
  assign flag_zero  = zero_r;
  assign flag_carry = carry_r;
  assign flag_ovf   = ovf_r;
  assign flag_err   = err_r;

  assign sum_s     = {1'b0, a} + {1'b0, b};
  assign is_iter_s = (sel == OP_MUL) || (sel == OP_DIV);

  // Single-cycle op results computed straight from the live operands.
  always_comb begin
    sc_res_s   = {WIDTH{1'b0}};
    sc_carry_s = 1'b0;
    sc_err_s   = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_res_s   = sum_s[WIDTH-1:0];
        sc_carry_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        sc_res_s   = a - b;
        sc_carry_s = (a < b);
      end
      OP_MUL:  sc_res_s = {WIDTH{1'b0}};
      OP_DIV:  sc_res_s = {WIDTH{1'b0}};
      OP_SHL:  sc_res_s = {a[WIDTH-2:0], 1'b0};
      OP_SHR:  sc_res_s = {1'b0, a[WIDTH-1:1]};
      OP_NAND: sc_res_s = ~(a & b);
      OP_XOR:  sc_res_s = a ^ b;
      OP_PRY:  sc_res_s = a ^ b;
      OP_PRZ:  sc_res_s = (a & b) ^ c;
      OP_FRY:  sc_res_s = (~a & b) | (a & c);
      OP_FRZ:  sc_res_s = (a & b) | (~a & c);
      default: begin
        sc_res_s = {WIDTH{1'b0}};
        sc_err_s = 1'b1;
      end
    endcase
  end

  // One shift-add / restoring-divide step, plus the final result taken
  // from the step that completes the last iteration.
  always_comb begin
    if (mplier_r[0]) begin
      acc_nx_s = acc_r + mcand_r;
    end else begin
      acc_nx_s = acc_r;
    end
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    qbit_s    = (shifted_s >= {1'b0, dvsr_r});
    // When the trial subtraction succeeds the true remainder is below the
    // divisor, so a WIDTH-bit subtraction is exact.
    if (qbit_s) begin
      rem_nx_s = shifted_s[WIDTH-1:0] - dvsr_r;
    end else begin
      rem_nx_s = shifted_s[WIDTH-1:0];
    end
    quo_nx_s = {quo_r[WIDTH-2:0], qbit_s};
    if (op_div_r) begin
      fin_res_s = dvz_r ? {WIDTH{1'b0}} : quo_nx_s;
      fin_ovf_s = 1'b0;
      fin_err_s = dvz_r;
    end else begin
      fin_res_s = acc_nx_s[WIDTH-1:0];
      fin_ovf_s = |acc_nx_s[2*WIDTH-1:WIDTH];
      fin_err_s = 1'b0;
    end
  end

  // Next-state logic and accept/finish strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s   = 1'b1;
          state_nx_s = is_iter_s ? ST_BUSY : ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (count_r == LAST_CNT) begin
          finish_s   = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Iterative datapath: load operands on accept, step once per BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {CW{1'b0}};
      op_div_r <= 1'b0;
      dvz_r    <= 1'b0;
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvsr_r   <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      count_r  <= {CW{1'b0}};
      op_div_r <= (sel == OP_DIV);
      dvz_r    <= (b == {WIDTH{1'b0}});
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= a;
      dvsr_r   <= b;
    end else if (state_r == ST_BUSY) begin
      count_r  <= count_r + CW'(1);
      acc_r    <= acc_nx_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      rem_r    <= rem_nx_s;
      quo_r    <= quo_nx_s;
    end
  end

  // Output registers: handshake bits follow the next state; result and
  // flags load on single-cycle accept or on the last iteration and are
  // otherwise held, so they stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_r       <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
      if (accept_s && !is_iter_s) begin
        out_r   <= sc_res_s;
        zero_r  <= (sc_res_s == {WIDTH{1'b0}});
        carry_r <= sc_carry_s;
        ovf_r   <= 1'b0;
        err_r   <= sc_err_s;
      end else if (finish_s) begin
        out_r   <= fin_res_s;
        zero_r  <= (fin_res_s == {WIDTH{1'b0}});
        carry_r <= 1'b0;
        ovf_r   <= fin_ovf_s;
        err_r   <= fin_err_s;
      end
    end
  end

endmodule

// File: tb/tb_rev_alu_seq.sv
// Directed self-checking bench for rev_alu_seq (WIDTH=8) with an
// expected-result queue filled at issue time and drained at output time.
module tb_rev_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       flag_zero;
  logic       flag_carry;
  logic       flag_ovf;
  logic       flag_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       cy;
    logic       ov;
    logic       er;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  rev_alu_seq #(.WIDTH(8), .OPW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .c          (c),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_err   (flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one op, check the result against the queued expectation, hold
  // backpressure for 'hold' cycles, then consume.
  task automatic do_op(input string tag, input logic [3:0] s, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [7:0] cc, input logic [7:0] eo,
                       input logic ez, input logic ec, input logic eov, input logic eer,
                       input int elat, input int hold);
    exp_t e;
    exp_t got;
    int lat;
    e.res = eo; e.z = ez; e.cy = ec; e.ov = eov; e.er = eer; e.lat = elat;
    sb_q.push_back(e);
    out_ready = (hold == 0);
    sel = s; a = aa; b = bb; c = cc;
    in_valid = 1'b1;
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    a = ~aa; b = ~bb; c = ~cc; sel = 4'd7;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sb_q.pop_front();
    chk({tag, ".lat"}, 32'(lat), 32'(got.lat));
    chk({tag, ".out"}, 32'(out), 32'(got.res));
    chk({tag, ".zero"}, 32'(flag_zero), 32'(got.z));
    chk({tag, ".carry"}, 32'(flag_carry), 32'(got.cy));
    chk({tag, ".ovf"}, 32'(flag_ovf), 32'(got.ov));
    chk({tag, ".err"}, 32'(flag_err), 32'(got.er));
    for (int i = 0; i < hold; i++) begin
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_out"}, 32'(out), 32'(got.res));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      if (i == 1) begin
        in_valid = 1'b1; sel = 4'd0; a = 8'd3; b = 8'd4;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".consumed_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".consumed_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'd0; b = 8'd0; c = 8'd0; sel = 4'd0;
    #12;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out", 32'(out), 32'd0);
    chk("reset.flags", 32'({flag_zero, flag_carry, flag_ovf, flag_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // add leaves a nonzero out so the mid-op reset clearing it is visible
    do_op("add200_100", 4'd0, 8'd200, 8'd100, 8'd0, 8'd44, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);

    // reset during BUSY of mul 15*17
    sel = 4'd2; a = 8'd15; b = 8'd17; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("abort.busy_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.out", 32'(out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort.no_result", 32'(seen), 32'd0);
    do_op("add1_1", 4'd0, 8'd1, 8'd1, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

    do_op("sub5_7", 4'd1, 8'd5, 8'd7, 8'd0, 8'd254, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    do_op("sub7_7", 4'd1, 8'd7, 8'd7, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("mul15_17", 4'd2, 8'd15, 8'd17, 8'd0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0);
    do_op("mul16_16", 4'd2, 8'd16, 8'd16, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 9, 0);
    do_op("div200_7", 4'd3, 8'd200, 8'd7, 8'd0, 8'd28, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0);
    do_op("div9_0", 4'd3, 8'd9, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 9, 0);
    do_op("rsvd13", 4'd13, 8'd9, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0);
    do_op("shl81", 4'd4, 8'h81, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("shr81", 4'd5, 8'h81, 8'h00, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("nand", 4'd6, 8'hF0, 8'hAA, 8'h00, 8'h5F, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("peres_z", 4'd9, 8'hF0, 8'hAA, 8'h55, 8'hF5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("fredkin_y", 4'd10, 8'hF0, 8'hAA, 8'h55, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("fredkin_z", 4'd11, 8'hF0, 8'hAA, 8'h55, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("peres_y", 4'd8, 8'hF0, 8'hAA, 8'h55, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

    // backpressure with a pulsed in_valid that must be dropped
    do_op("bp_xor", 4'd7, 8'h0F, 8'hFF, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 5);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("bp.pulse_ignored", 32'(seen), 32'd0);
    chk("bp.queue_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
